// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: shares one register file between requesters A and B (dedicated reads, round-robin write port, clear sweep)
// Ports: Clk/Reset; clr_start pulse starts the sweep, clr_busy flags it; a_*/b_* are the requester handshakes
// (req held until ack, rdata valid with ack); rf_* drive the register file's write port and two combinational read ports.
module regfile_access_ctrl #(
  parameter int AW = 5,
  parameter int DW = 32,
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          clr_start,
  output logic          clr_busy,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic [AW-1:0] rf_raddr_a,
  output logic [AW-1:0] rf_raddr_b,
  input  logic [DW-1:0] rf_rdata_a,
  input  logic [DW-1:0] rf_rdata_b
);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_n;
  logic rr_b;
  logic [AW-1:0] cnt;
  logic idle_ok, a_rd, b_rd, a_wt, b_wt, a_wr, b_wr;
  assign rf_raddr_a = a_addr;
  assign rf_raddr_b = b_addr;
  assign clr_busy = state == CLEAR;
  // A requester in its ack cycle is not eligible, so every ack is followed by a dead cycle.
  always_comb begin
    idle_ok = state == IDLE && !clr_start;
    a_rd = idle_ok && a_req && !a_ack && !a_we;
    b_rd = idle_ok && b_req && !b_ack && !b_we;
    a_wt = idle_ok && a_req && !a_ack && a_we;
    b_wt = idle_ok && b_req && !b_ack && b_we;
    a_wr = a_wt && (!b_wt || !rr_b);
    b_wr = b_wt && (!a_wt || rr_b);
    state_n = state == IDLE ? (clr_start ? CLEAR : IDLE) : (cnt == '1 ? IDLE : CLEAR);
    rf_waddr = clr_busy ? cnt : (b_wr ? b_addr : a_addr);
    rf_wdata = clr_busy ? '0 : (b_wr ? b_wdata : a_wdata);
    rf_we = !Reset && (clr_busy || ((a_wr || b_wr) && !(ZERO_R0 && rf_waddr == '0)));
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rr_b <= 1'b0;
      cnt <= '0;
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      a_ack <= a_rd || a_wr;
      b_ack <= b_rd || b_wr;
      if (a_rd) a_rdata <= rf_rdata_a;
      if (b_rd) b_rdata <= rf_rdata_b;
      cnt <= clr_busy ? cnt + 1'b1 : '0;
      rr_b <= clr_busy ? 1'b0 : a_wr ? 1'b1 : b_wr ? 1'b0 : rr_b;
    end
  end
endmodule

// File: tb/tb_regfile_access_ctrl.sv
// tb_regfile_access_ctrl: directed and randomized checks of regfile_access_ctrl (ZERO_R0=0 and ZERO_R0=1 instances)
module tb_regfile_access_ctrl;
  logic Clk = 1'b0, Reset = 1'b1, clr_start = 1'b0;
  logic a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [4:0] a_addr = '0, b_addr = '0;
  logic [31:0] a_wdata = '0, b_wdata = '0;
  logic clr_busy, a_ack, b_ack, rf_we;
  logic [31:0] a_rdata, b_rdata, rf_wdata, rf_rdata_a, rf_rdata_b;
  logic [4:0] rf_waddr, rf_raddr_a, rf_raddr_b;
  logic z_clr_busy, z_a_ack, z_b_ack, z_rf_we;
  logic [31:0] z_a_rdata, z_b_rdata, z_rf_wdata, z_rf_rdata_a, z_rf_rdata_b;
  logic [4:0] z_rf_waddr, z_rf_raddr_a, z_rf_raddr_b;
  logic [31:0] rf0 [32] = '{default: '0};
  logic [31:0] rf1 [32] = '{default: '0};
  logic [31:0] sh0 [32];
  logic [31:0] sh1 [32];
  int n_chk = 0, n_fail = 0, a_wait = 0, b_wait = 0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) if (rf_we) rf0[rf_waddr] <= rf_wdata;
  always @(posedge Clk) if (z_rf_we) rf1[z_rf_waddr] <= z_rf_wdata;
  assign rf_rdata_a = rf0[rf_raddr_a];
  assign rf_rdata_b = rf0[rf_raddr_b];
  assign z_rf_rdata_a = rf1[z_rf_raddr_a];
  assign z_rf_rdata_b = rf1[z_rf_raddr_b];

  regfile_access_ctrl #(.AW(5), .DW(32), .ZERO_R0(1'b0)) dut (
    .Clk(Clk), .Reset(Reset), .clr_start(clr_start), .clr_busy(clr_busy),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b));

  regfile_access_ctrl #(.AW(5), .DW(32), .ZERO_R0(1'b1)) dut_z (
    .Clk(Clk), .Reset(Reset), .clr_start(clr_start), .clr_busy(z_clr_busy),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(z_a_ack), .a_rdata(z_a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(z_b_ack), .b_rdata(z_b_rdata),
    .rf_we(z_rf_we), .rf_waddr(z_rf_waddr), .rf_wdata(z_rf_wdata), .rf_raddr_a(z_rf_raddr_a), .rf_raddr_b(z_rf_raddr_b),
    .rf_rdata_a(z_rf_rdata_a), .rf_rdata_b(z_rf_rdata_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    a_req = 1'b0;
    b_req = 1'b0;
    clr_start = 1'b0;
    tick();
    Reset = 1'b0;
  endtask

  initial begin
    // reset state, and no write while Reset is high even with a write pending
    tick();
    tick();
    chk("rst_busy", clr_busy, 0);
    chk("rst_a_ack", a_ack, 0);
    chk("rst_b_ack", b_ack, 0);
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_b_rdata", b_rdata, 0);
    a_req = 1; a_we = 1; a_addr = 3; a_wdata = 32'h8000_1111;
    #1 chk("rst_we", rf_we, 0);
    Reset = 0;
    #1 chk("w3_we", rf_we, 1);
    chk("w3_waddr", rf_waddr, 3);
    chk("w3_wdata", rf_wdata, 32'h8000_1111);
    tick();
    chk("w3_ack", a_ack, 1);
    a_we = 0;
    #1 chk("r3_dead_we", rf_we, 0);
    tick();
    chk("r3_dead_ack", a_ack, 0);
    tick();
    chk("r3_ack", a_ack, 1);
    chk("r3_rdata", a_rdata, 32'h8000_1111);
    a_req = 0;
    // contended writes: rr starts at A after reset
    do_reset();
    a_req = 1; a_we = 1; a_addr = 1; a_wdata = 32'h0000_0001;
    b_req = 1; b_we = 1; b_addr = 2; b_wdata = 32'h7FFF_FFFF;
    #1 chk("rr1_waddr", rf_waddr, 1);
    tick();
    chk("rr1_a_ack", a_ack, 1);
    chk("rr1_b_ack", b_ack, 0);
    a_req = 0;
    #1 chk("rr1_b_we", rf_we, 1);
    chk("rr1_b_waddr", rf_waddr, 2);
    tick();
    chk("rr1_b_ack2", b_ack, 1);
    chk("rr1_a_ack2", a_ack, 0);
    b_req = 0;
    tick();
    a_req = 1; a_addr = 6; a_wdata = 32'h66;
    tick();
    chk("w6_ack", a_ack, 1);
    a_req = 0;
    tick();
    a_req = 1; a_addr = 1; a_wdata = 32'hAAAA;
    b_req = 1; b_addr = 2; b_wdata = 32'hBBBB;
    #1 chk("rr2_waddr", rf_waddr, 2);
    tick();
    chk("rr2_b_ack", b_ack, 1);
    chk("rr2_a_ack", a_ack, 0);
    b_req = 0;
    tick();
    chk("rr2_a_ack2", a_ack, 1);
    a_req = 0;
    tick();
    chk("rr2_r1", rf0[1], 32'hAAAA);
    chk("rr2_r2", rf0[2], 32'hBBBB);
    // same-cycle write/read hazard returns the old value
    a_req = 1; a_we = 1; a_addr = 5; a_wdata = 32'h1234_5678;
    b_req = 1; b_we = 0; b_addr = 5;
    tick();
    chk("hz_a_ack", a_ack, 1);
    chk("hz_b_ack", b_ack, 1);
    chk("hz_b_old", b_rdata, 0);
    a_req = 0;
    tick();
    chk("hz_b_dead", b_ack, 0);
    tick();
    chk("hz_b_ack2", b_ack, 1);
    chk("hz_b_new", b_rdata, 32'h1234_5678);
    b_req = 0;
    tick();
    // fill, then clear with a read pending
    for (int i = 0; i < 32; i++) begin
      a_req = 1; a_we = 1; a_addr = 5'(i); a_wdata = 32'hA5A5_0000 | i;
      tick();
      chk("fill_ack", a_ack, 1);
      a_req = 0;
      tick();
    end
    chk("fill_r31", rf0[31], 32'hA5A5_001F);
    a_req = 1; a_we = 0; a_addr = 7; clr_start = 1;
    #1 chk("clr_nogrant", rf_we, 0);
    tick();
    clr_start = 0;
    for (int k = 0; k < 32; k++) begin
      chk("clr_busy", clr_busy, 1);
      chk("clr_we", rf_we, 1);
      chk("clr_waddr", rf_waddr, k);
      chk("clr_wdata", rf_wdata, 0);
      chk("clr_a_ack", a_ack, 0);
      tick();
    end
    chk("clr_done", clr_busy, 0);
    chk("clr_a_ack_end", a_ack, 0);
    tick();
    chk("clr_a_ack_post", a_ack, 1);
    chk("clr_a_rdata", a_rdata, 0);
    a_req = 0;
    tick();
    for (int i = 0; i < 32; i++) begin
      a_req = 1; a_addr = 5'(i);
      tick();
      chk("clr_rd_ack", a_ack, 1);
      chk("clr_rd", a_rdata, 0);
      a_req = 0;
      tick();
    end
    a_req = 1; a_we = 1; a_addr = 8; a_wdata = 32'h11;
    b_req = 1; b_we = 1; b_addr = 9; b_wdata = 32'h22;
    tick();
    chk("clr_rr_a", a_ack, 1);
    chk("clr_rr_b", b_ack, 0);
    a_req = 0;
    tick();
    chk("clr_rr_b2", b_ack, 1);
    b_req = 0;
    tick();
    // ZERO_R0 instance drops writes to r0 but still acks
    a_req = 1; a_we = 1; a_addr = 0; a_wdata = 32'hFFFF_FFFF;
    #1 chk("z0_we", z_rf_we, 0);
    chk("z0_we_ref", rf_we, 1);
    tick();
    chk("z0_ack", z_a_ack, 1);
    a_we = 0;
    tick();
    tick();
    chk("z0_rd_ack", z_a_ack, 1);
    chk("z0_rd", z_a_rdata, 0);
    chk("z0_rd_ref", a_rdata, 32'hFFFF_FFFF);
    a_req = 0;
    tick();
    // reset in the middle of a clear aborts it
    a_req = 1; a_we = 1; a_addr = 20; a_wdata = 32'hDEAD_BEEF;
    tick();
    chk("w20_ack", a_ack, 1);
    a_req = 0;
    tick();
    clr_start = 1;
    tick();
    clr_start = 0;
    repeat (10) tick();
    chk("ab_waddr", rf_waddr, 10);
    Reset = 1;
    #1 chk("ab_busy", clr_busy, 0);
    chk("ab_we", rf_we, 0);
    tick();
    Reset = 0;
    for (int k = 0; k < 3; k++) begin
      #1 chk("ab_idle_busy", clr_busy, 0);
      chk("ab_idle_we", rf_we, 0);
      tick();
    end
    chk("ab_r0", rf0[0], 0);
    chk("ab_r20", rf0[20], 32'hDEAD_BEEF);
    a_req = 1; a_we = 1; a_addr = 11; a_wdata = 32'h33;
    b_req = 1; b_we = 1; b_addr = 12; b_wdata = 32'h44;
    tick();
    chk("ab_rr_a", a_ack, 1);
    chk("ab_rr_b", b_ack, 0);
    a_req = 0;
    tick();
    b_req = 0;
    tick();
    // randomized traffic against a shadow memory, starting from a cleared file
    clr_start = 1;
    tick();
    clr_start = 0;
    repeat (33) tick();
    for (int i = 0; i < 32; i++) begin
      sh0[i] = '0;
      sh1[i] = '0;
    end
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (a_ack) begin
        chk("rnd_a_spur", a_req, 1);
        if (!a_we) begin
          chk("rnd_a_rd", a_rdata, sh0[a_addr]);
          chk("rnd_z_a_ack", z_a_ack, 1);
          chk("rnd_z_a_rd", z_a_rdata, sh1[a_addr]);
        end
      end
      if (b_ack) begin
        chk("rnd_b_spur", b_req, 1);
        if (!b_we) begin
          chk("rnd_b_rd", b_rdata, sh0[b_addr]);
          chk("rnd_z_b_ack", z_b_ack, 1);
          chk("rnd_z_b_rd", z_b_rdata, sh1[b_addr]);
        end
      end
      chk("rnd_wr_both", a_ack && b_ack && a_req && b_req && a_we && b_we, 0);
      if (a_ack && a_req && a_we) begin
        sh0[a_addr] = a_wdata;
        if (a_addr != 0) sh1[a_addr] = a_wdata;
      end
      if (b_ack && b_req && b_we) begin
        sh0[b_addr] = b_wdata;
        if (b_addr != 0) sh1[b_addr] = b_wdata;
      end
      if (a_req && !a_ack) begin
        a_wait++;
        chk("rnd_a_lat", a_wait <= 2, 1);
      end
      if (b_req && !b_ack) begin
        b_wait++;
        chk("rnd_b_lat", b_wait <= 2, 1);
      end
      if (!a_req || a_ack) begin
        a_req = ($urandom_range(0, 3) != 0) && (c < 2990);
        a_we = 1'($urandom_range(0, 1));
        a_addr = 5'($urandom_range(0, 7));
        a_wdata = $urandom;
        a_wait = 0;
      end
      if (!b_req || b_ack) begin
        b_req = ($urandom_range(0, 3) != 0) && (c < 2990);
        b_we = 1'($urandom_range(0, 1));
        b_addr = 5'($urandom_range(0, 7));
        b_wdata = $urandom;
        b_wait = 0;
      end
      #1 chk("rnd_raddr_a", rf_raddr_a, a_addr);
      chk("rnd_raddr_b", rf_raddr_b, b_addr);
    end
    tick();
    for (int i = 0; i < 32; i++) begin
      chk("end_rf", rf0[i], sh0[i]);
      chk("end_rf_z", rf1[i], sh1[i]);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
